// File: rtl/pe_row_drain_pkg.sv
// Shared definitions for the PE row output-drain controller.
package pe_row_drain_pkg;

  // Data width matching PE_H psum/output registers.
  localparam int unsigned DefaultDw = 16;

  // Drain FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2
  } drain_state_e;

  // Broadcast PE control bus, MSB to LSB: clear_psum, en_out, output_eject_ctrl.
  typedef struct packed {
    logic clear_psum;
    logic en_out;
    logic eject;
  } pe_ctrl_t;

  localparam pe_ctrl_t CtrlNone = '{clear_psum: 1'b0, en_out: 1'b0, eject: 1'b0};

endpackage

// File: rtl/pe_row_drain_sync_fifo.sv
// Synchronous FIFO for drained words. Read data is forced to zero while empty so
// the stream outputs are clean after reset.
module pe_row_drain_sync_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             wr, rd;

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);
  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally (power-of-two depth); occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_row_drain.sv
// Output-drain controller for a row of PE_H cells: snapshots psums into the
// output_reg chain, shifts the chain into a FIFO and streams it out.
module pe_row_drain
  import pe_row_drain_pkg::*;
#(
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_drain,
  input  logic [DW-1:0] row_out_in,
  output logic          output_eject_ctrl,
  output logic          en_out,
  output logic          clear_psum,
  output logic          busy,
  output logic          drain_done,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int unsigned CntW = $clog2(NUM_PE);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_PE - 1);

  drain_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          done_q;
  logic          fifo_full, fifo_empty;
  logic          push, last_word;
  pe_ctrl_t      ctrl;

  // A stalled chain simply holds; nothing is shifted unless the FIFO can take it.
  assign push      = (state_q == StShift) && !fifo_full;
  assign last_word = (cnt_q == LastCnt);

  // Next-state and PE control decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CtrlNone;
    unique case (state_q)
      StIdle: begin
        if (start_drain) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        ctrl.en_out     = 1'b1;
        ctrl.clear_psum = 1'b1;
        state_d         = StShift;
      end
      StShift: begin
        ctrl.eject = 1'b1;
        if (push) begin
          ctrl.en_out = 1'b1;
          cnt_d       = cnt_q + CntW'(1);
          if (last_word) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, word counter and drain_done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= push && last_word;
    end
  end

  assign output_eject_ctrl = ctrl.eject;
  assign en_out            = ctrl.en_out;
  assign clear_psum        = ctrl.clear_psum;
  assign busy              = (state_q != StIdle);
  assign drain_done        = done_q;
  assign m_valid           = !fifo_empty;

  pe_row_drain_sync_fifo #(
    .Width (DW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({last_word, row_out_in}),
    .rd_en   (m_ready),
    .rd_data ({m_last, m_data}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
